// File: rtl/nebula_pkg.sv
// Shared NoC types for the nebula packet path: flit layout, flit/error codes,
// field widths and the flit-count helper used by assembler and disassembler.
package nebula_pkg;

  localparam int unsigned COORD_WIDTH        = 4;
  localparam int unsigned VC_ID_WIDTH        = 2;
  localparam int unsigned QOS_WIDTH          = 4;
  localparam int unsigned SEQ_WIDTH          = 8;
  localparam int unsigned PKT_ID_WIDTH       = 8;
  localparam int unsigned FLIT_PAYLOAD_WIDTH = 208;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_SINGLE = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PROTOCOL = 2'd1
  } error_code_e;

  // Routing/header fields replicated into every flit of a packet
  typedef struct packed {
    logic [COORD_WIDTH-1:0] src_x;
    logic [COORD_WIDTH-1:0] src_y;
    logic [COORD_WIDTH-1:0] dest_x;
    logic [COORD_WIDTH-1:0] dest_y;
    logic [VC_ID_WIDTH-1:0] vc_id;
    logic [QOS_WIDTH-1:0]   qos;
  } pkt_hdr_t;

  typedef struct packed {
    flit_type_e                    flit_type;
    logic [PKT_ID_WIDTH-1:0]       packet_id;
    logic [SEQ_WIDTH-1:0]          seq_num;
    logic [COORD_WIDTH-1:0]        src_x;
    logic [COORD_WIDTH-1:0]        src_y;
    logic [COORD_WIDTH-1:0]        dest_x;
    logic [COORD_WIDTH-1:0]        dest_y;
    logic [VC_ID_WIDTH-1:0]        vc_id;
    logic [QOS_WIDTH-1:0]          qos;
    logic [FLIT_PAYLOAD_WIDTH-1:0] payload;
  } noc_flit_t;

  // Number of flits for a payload of size_bytes; an empty payload still needs one
  function automatic int unsigned calc_num_flits(input int unsigned size_bytes);
    int unsigned n;
    n = (size_bytes * 8 + FLIT_PAYLOAD_WIDTH - 1) / FLIT_PAYLOAD_WIDTH;
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/nebula_packet_assembler.sv
// Transmit-side segmenter: registers one packet and streams it as
// SINGLE or HEAD/BODY*/TAIL flits into the router injection port.
// Optional build macro NEBULA_PKT_ASM_STATS_EN adds packet/flit handshake counters.
module nebula_packet_assembler
  import nebula_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD_SIZE = 1024,
  parameter int unsigned FLITS_PER_PACKET = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pkt_valid,
  input  logic [COORD_WIDTH-1:0]              src_x,
  input  logic [COORD_WIDTH-1:0]              src_y,
  input  logic [COORD_WIDTH-1:0]              dest_x,
  input  logic [COORD_WIDTH-1:0]              dest_y,
  input  logic [VC_ID_WIDTH-1:0]              vc_id,
  input  logic [QOS_WIDTH-1:0]                qos,
  input  logic [MAX_PAYLOAD_SIZE*8-1:0]       payload_data,
  input  logic [$clog2(MAX_PAYLOAD_SIZE)-1:0] payload_size,
  output logic                                pkt_ready,
  output logic                                flit_valid,
  output noc_flit_t                           flit_out,
  input  logic                                flit_ready,
  output logic                                error_detected,
  output error_code_e                         error_code
`ifdef NEBULA_PKT_ASM_STATS_EN
  ,
  output logic [31:0]                         stat_pkt_count,
  output logic [31:0]                         stat_flit_count
`endif
);

  localparam int unsigned FPW       = FLIT_PAYLOAD_WIDTH;
  localparam int unsigned NF_W      = $clog2(FLITS_PER_PACKET + 1);
  localparam int unsigned BUF_BITS  = FLITS_PER_PACKET * FPW;
  localparam int unsigned BUF_BYTES = BUF_BITS / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PKT_ID_WIDTH-1:0] pkt_id_q, pkt_id_d;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
  logic [NF_W-1:0]         flit_idx_q, flit_idx_d;
  logic [NF_W-1:0]         nflits_q, nflits_d;
  logic                    pkt_ready_d;
  logic                    flit_valid_d;
  noc_flit_t               flit_out_d;
  logic                    error_detected_d;
  error_code_e             error_code_d;
  logic                    load_c;

  pkt_hdr_t                hdr_in, hdr_q;
  logic [BUF_BITS-1:0]     pay_in_masked, pay_q;
  int unsigned             n_in;
  logic [NF_W-1:0]         nxt_idx;
  logic                    flit_hs, is_last, tail_hs;

  // Only the first FLITS_PER_PACKET flits of payload can ever be emitted
  logic unused_payload_hi;
  assign unused_payload_hi = ^payload_data[MAX_PAYLOAD_SIZE*8-1:BUF_BITS];

  function automatic flit_type_e flit_kind(input logic [NF_W-1:0] idx,
                                           input logic [NF_W-1:0] n);
    if (n == NF_W'(1))             return FLIT_SINGLE;
    else if (idx == '0)            return FLIT_HEAD;
    else if (idx == n - NF_W'(1))  return FLIT_TAIL;
    else                           return FLIT_BODY;
  endfunction

  function automatic logic [FPW-1:0] sel_flit(input logic [BUF_BITS-1:0] buf_bits,
                                              input logic [NF_W-1:0]     idx);
    logic [FPW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < FLITS_PER_PACKET; k++)
      if (NF_W'(k) == idx) r = buf_bits[k*FPW +: FPW];
    return r;
  endfunction

  function automatic noc_flit_t pack_flit(input flit_type_e              t,
                                          input logic [PKT_ID_WIDTH-1:0] id,
                                          input logic [SEQ_WIDTH-1:0]    seq,
                                          input pkt_hdr_t                h,
                                          input logic [FPW-1:0]          pl);
    noc_flit_t f;
    f.flit_type = t;
    f.packet_id = id;
    f.seq_num   = seq;
    f.src_x     = h.src_x;
    f.src_y     = h.src_y;
    f.dest_x    = h.dest_x;
    f.dest_y    = h.dest_y;
    f.vc_id     = h.vc_id;
    f.qos       = h.qos;
    f.payload   = pl;
    return f;
  endfunction

  assign hdr_in  = '{src_x: src_x, src_y: src_y, dest_x: dest_x, dest_y: dest_y,
                     vc_id: vc_id, qos: qos};
  assign n_in    = calc_num_flits(32'(payload_size));
  assign nxt_idx = flit_idx_q + NF_W'(1);
  assign flit_hs = (state_q == ST_SEND) && flit_valid && flit_ready;
  assign is_last = (flit_idx_q == nflits_q - NF_W'(1));
  assign tail_hs = flit_hs && is_last;

  // Zero every payload byte at or beyond payload_size
  always_comb begin
    pay_in_masked = '0;
    for (int unsigned i = 0; i < BUF_BYTES; i++)
      if (i < 32'(payload_size)) pay_in_masked[i*8 +: 8] = payload_data[i*8 +: 8];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    pkt_id_d         = pkt_id_q;
    seq_d            = seq_q;
    flit_idx_d       = flit_idx_q;
    nflits_d         = nflits_q;
    pkt_ready_d      = pkt_ready;
    flit_valid_d     = flit_valid;
    flit_out_d       = flit_out;
    error_detected_d = 1'b0;
    error_code_d     = error_code;
    load_c           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          if (n_in > FLITS_PER_PACKET) begin
            error_detected_d = 1'b1;
            error_code_d     = ERR_PROTOCOL;
          end else begin
            load_c       = 1'b1;
            state_d      = ST_SEND;
            pkt_ready_d  = 1'b0;
            flit_valid_d = 1'b1;
            flit_idx_d   = '0;
            nflits_d     = NF_W'(n_in);
            flit_out_d   = pack_flit(flit_kind('0, NF_W'(n_in)), pkt_id_q, seq_q,
                                     hdr_in, pay_in_masked[FPW-1:0]);
          end
        end
      end
      ST_SEND: begin
        if (flit_hs) begin
          if (is_last) begin
            state_d      = ST_IDLE;
            pkt_ready_d  = 1'b1;
            flit_valid_d = 1'b0;
            pkt_id_d     = pkt_id_q + PKT_ID_WIDTH'(1);
            seq_d        = seq_q + SEQ_WIDTH'(nflits_q);
          end else begin
            flit_idx_d = nxt_idx;
            flit_out_d = pack_flit(flit_kind(nxt_idx, nflits_q), pkt_id_q,
                                   seq_q + SEQ_WIDTH'(nxt_idx), hdr_q,
                                   sel_flit(pay_q, nxt_idx));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pkt_id_q       <= '0;
      seq_q          <= '0;
      flit_idx_q     <= '0;
      nflits_q       <= '0;
      pkt_ready      <= 1'b1;
      flit_valid     <= 1'b0;
      flit_out       <= '0;
      error_detected <= 1'b0;
      error_code     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      pkt_id_q       <= pkt_id_d;
      seq_q          <= seq_d;
      flit_idx_q     <= flit_idx_d;
      nflits_q       <= nflits_d;
      pkt_ready      <= pkt_ready_d;
      flit_valid     <= flit_valid_d;
      flit_out       <= flit_out_d;
      error_detected <= error_detected_d;
      error_code     <= error_code_d;
    end
  end

  // Packet capture on acceptance
  always_ff @(posedge clk) begin
    if (load_c) begin
      hdr_q <= hdr_in;
      pay_q <= pay_in_masked;
    end
  end

`ifdef NEBULA_PKT_ASM_STATS_EN
  // Handshake statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_count  <= '0;
      stat_flit_count <= '0;
    end else begin
      if (flit_hs) stat_flit_count <= stat_flit_count + 32'd1;
      if (tail_hs) stat_pkt_count  <= stat_pkt_count + 32'd1;
    end
  end
`else
  logic unused_tail_hs;
  assign unused_tail_hs = tail_hs;
`endif

endmodule
